control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Microcode sequencer for the 8-bit bus machine.
- Steps through fetch and execute T-states and drives every bus control line: memory, instruction register, program counter, A/B registers, ALU, output, and flags.
- Reads the opcode from the instruction register and the latched carry/zero flags.
- It is the initiator for all load/write strobes (AI, BI, AO, BO, EO, SU, ...) that the datapath blocks respond to.

Parameters:
- STEPS, 5, maximum T-states per instruction (T0..T4); counter width is 3 bits.
- OP_W, 4, opcode width taken from instruction register high nibble.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-low reset
- opcode  input  OP_W  instruction register high nibble
- carry_flag  input  1  latched carry from flags register
- zero_flag  input  1  latched zero from flags register
- HLT  output  1  halt clock / halted indicator
- MI  output  1  memory address register in
- RI  output  1  RAM in (write)
- RO  output  1  RAM out
- II  output  1  instruction register in
- IO  output  1  instruction register operand (low nibble) out
- AI  output  1  A register in
- AO  output  1  A register out
- BI  output  1  B register in
- BO  output  1  B register out
- EO  output  1  ALU sum out
- SU  output  1  ALU subtract
- FI  output  1  flags register in
- OI  output  1  output register in
- CE  output  1  program counter increment
- CO  output  1  program counter out
- J  output  1  program counter load (jump)
- step  output  3  current T-state, for debug/display

Behaviour:
- State: step counter (0..4) and halted bit. Reset (rst==0 at rising edge): step=0, halted=0.
- While rst==0, all control outputs forced 0 combinationally, so nothing drives the bus. step output shows the register value.
- Control outputs are a Moore decode of (step, opcode, flags, halted). They are valid for the whole cycle and are consumed by datapath at the next rising edge.
- At most one bus driver asserted per step (CO, RO, IO, AO, BO, EO mutually exclusive).
- Fetch, all opcodes:
  - T0: CO MI
  - T1: RO II CE
- Execute (T2..T4); after the last listed step, next step = 0:
  - 0000 NOP: T2 none. Length 3.
  - 0001 LDA: T2 IO MI; T3 RO AI. Length 4.
  - 0010 ADD: T2 IO MI; T3 RO BI; T4 EO AI FI. Length 5.
  - 0011 SUB: as ADD, with SU asserted in T4 only. Length 5.
  - 0100 STA: T2 IO MI; T3 AO RI. Length 4.
  - 0101 LDI: T2 IO AI. Length 3.
  - 0110 JMP: T2 IO J. Length 3.
  - 0111 JC: T2 IO J if carry_flag==1, else none. Length 3.
  - 1000 JZ: T2 IO J if zero_flag==1, else none. Length 3.
  - 1110 OUT: T2 AO OI. Length 3.
  - 1111 HLT: T2 HLT; at the following edge halted=1.
  - Undefined opcodes (1001..1101) execute as NOP.
- Opcode is sampled combinationally in T2..T4 only. Its value during T0/T1 is ignored (the instruction register updates at end of T1).
- Flags are sampled in T2 of JC/JZ only. Flag changes in other steps have no effect.
- Halted: HLT=1, all other outputs 0, step frozen at its value. Only reset exits halted.
- Reset mid-instruction: the next cycle is T0 with outputs CO MI. No partial strobe is emitted during the reset cycle.
- step never exceeds 4. An illegal counter value (not reachable) returns to 0 on the next edge.

Test Plan:
- Reset then release with opcode=0000 -> cycle 1: CO MI; cycle 2: RO II CE; cycle 3: no outputs; cycle 4: step=0, CO MI.
- opcode=0010 held from T2 -> T2 IO MI, T3 RO BI, T4 EO AI FI with SU=0, then step=0. Repeat with 0011 -> identical except SU=1 only in T4.
- opcode=0111: carry_flag=1 -> T2 IO J; carry_flag=0 -> T2 all zero. Step returns to 0 after T2 in both cases. Repeat for 1000 with zero_flag.
- opcode=1111 -> T2 HLT=1; every later cycle HLT=1, all others 0, step constant for 20 cycles. Assert rst=0 for one cycle -> outputs 0 in that cycle; next cycle step=0, CO MI, HLT=0.
- Drive rst=0 during T3 of LDA (RO AI active) -> outputs all 0 in the reset cycle; following cycle T0 CO MI.
- All 16 opcodes, all flag combinations, every step -> no two of CO/RO/IO/AO/BO/EO high together; undefined opcodes match the NOP trace exactly.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: microcode T-state sequencer driving every bus control strobe
// of the 8-bit bus machine from (step, opcode, flags, halted).
module control_sequencer #(
   parameter int STEPS = 5,
   parameter int OP_W  = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [OP_W-1:0] opcode,
   input  logic            carry_flag,
   input  logic            zero_flag,
   output logic            HLT,
   output logic            MI,
   output logic            RI,
   output logic            RO,
   output logic            II,
   output logic            IO,
   output logic            AI,
   output logic            AO,
   output logic            BI,
   output logic            BO,
   output logic            EO,
   output logic            SU,
   output logic            FI,
   output logic            OI,
   output logic            CE,
   output logic            CO,
   output logic            J,
   output logic [2:0]      step
);
   typedef enum logic [2:0] {T0, T1, T2, T3, T4} step_e;
   step_e step_q;
   logic halted;
   logic t0, t1, t2, t3, t4, run;
   logic is_lda, is_add, is_sub, is_sta, is_ldi, is_jmp, is_jc, is_jz, is_out, is_hlt;
   logic mem_op, alu_op, jump;
   logic [2:0] last_step;
   assign t0 = step_q == T0;
   assign t1 = step_q == T1;
   assign t2 = step_q == T2;
   assign t3 = step_q == T3;
   assign t4 = step_q == T4;
   assign is_lda = opcode == OP_W'(4'b0001);
   assign is_add = opcode == OP_W'(4'b0010);
   assign is_sub = opcode == OP_W'(4'b0011);
   assign is_sta = opcode == OP_W'(4'b0100);
   assign is_ldi = opcode == OP_W'(4'b0101);
   assign is_jmp = opcode == OP_W'(4'b0110);
   assign is_jc  = opcode == OP_W'(4'b0111);
   assign is_jz  = opcode == OP_W'(4'b1000);
   assign is_out = opcode == OP_W'(4'b1110);
   assign is_hlt = opcode == OP_W'(4'b1111);
   assign alu_op = is_add | is_sub;
   assign mem_op = is_lda | is_sta | alu_op;
   assign jump   = is_jmp | (is_jc & carry_flag) | (is_jz & zero_flag);
   assign last_step = alu_op ? 3'(STEPS - 1) : (is_lda | is_sta) ? 3'd3 : 3'd2;
   // Illegal counter values are >= every last_step, so they also wrap to T0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         step_q <= T0;
         halted <= 1'b0;
      end else if (!halted) begin
         halted <= t2 & is_hlt;
         step_q <= (t2 & is_hlt) ? T2 :
                   (3'(step_q) >= last_step) ? T0 : step_e'(3'(step_q) + 3'd1);
      end
   end
   assign run  = rst & ~halted;
   assign step = step_q;
   assign HLT  = rst & (halted | (t2 & is_hlt));
   assign CO   = run & t0;
   assign MI   = run & (t0 | (t2 & mem_op));
   assign RO   = run & (t1 | (t3 & (is_lda | alu_op)));
   assign II   = run & t1;
   assign CE   = run & t1;
   assign IO   = run & t2 & (mem_op | is_ldi | jump);
   assign AI   = run & ((t2 & is_ldi) | (t3 & is_lda) | (t4 & alu_op));
   assign AO   = run & ((t2 & is_out) | (t3 & is_sta));
   assign RI   = run & t3 & is_sta;
   assign BI   = run & t3 & alu_op;
   assign BO   = 1'b0;
   assign EO   = run & t4 & alu_op;
   assign FI   = run & t4 & alu_op;
   assign SU   = run & t4 & is_sub;
   assign OI   = run & t2 & is_out;
   assign J    = run & t2 & jump;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: table-driven per-cycle check of control_sequencer strobes and step.
module tb_control_sequencer;
   logic clk = 1'b0, rst = 1'b0, carry_flag = 1'b0, zero_flag = 1'b0;
   logic [3:0] opcode = 4'd0;
   logic HLT, MI, RI, RO, II, IO, AI, AO, BI, BO, EO, SU, FI, OI, CE, CO, J;
   logic [2:0] step;
   logic [16:0] ctrl;
   int tests = 0, fails = 0;

   localparam logic [16:0] M_HLT = 17'h10000, M_MI = 17'h08000, M_RI = 17'h04000, M_RO = 17'h02000,
                           M_II = 17'h01000, M_IO = 17'h00800, M_AI = 17'h00400, M_AO = 17'h00200,
                           M_BI = 17'h00100, M_BO = 17'h00080, M_EO = 17'h00040, M_SU = 17'h00020,
                           M_FI = 17'h00010, M_OI = 17'h00008, M_CE = 17'h00004, M_CO = 17'h00002,
                           M_J = 17'h00001;
   localparam logic [16:0] F0 = M_CO | M_MI, F1 = M_RO | M_II | M_CE;
   localparam logic [16:0] BUS = M_CO | M_RO | M_IO | M_AO | M_BO | M_EO;

   control_sequencer dut (
      .clk(clk), .rst(rst), .opcode(opcode), .carry_flag(carry_flag), .zero_flag(zero_flag),
      .HLT(HLT), .MI(MI), .RI(RI), .RO(RO), .II(II), .IO(IO), .AI(AI), .AO(AO), .BI(BI),
      .BO(BO), .EO(EO), .SU(SU), .FI(FI), .OI(OI), .CE(CE), .CO(CO), .J(J), .step(step)
   );

   assign ctrl = {HLT, MI, RI, RO, II, IO, AI, AO, BI, BO, EO, SU, FI, OI, CE, CO, J};
   always #5 clk = ~clk;

   typedef struct {
      logic r;
      logic [3:0] op;
      logic c, z;
      logic [2:0] st;
      logic [16:0] ctl;
   } vec_t;
   vec_t vecs[$];

   task automatic add(input logic r, input logic [3:0] op, input logic c, input logic z,
                      input logic [2:0] st, input logic [16:0] ctl);
      vec_t v;
      v.r = r; v.op = op; v.c = c; v.z = z; v.st = st; v.ctl = ctl;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic r, input logic [3:0] op, input logic c, input logic z);
      @(posedge clk);
      #1;
      rst = r; opcode = op; carry_flag = c; zero_flag = z;
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [2:0] st, input logic [16:0] ctl);
      tests++;
      if (step !== st || ctrl !== ctl) begin
         fails++;
         $display("FAIL %s: got step=%0d ctrl=%05h, expected step=%0d ctrl=%05h", name, step, ctrl, st, ctl);
      end
   endtask

   initial begin
      // reset state, then NOP
      add(0, 4'h0, 0, 0, 0, 0);
      add(1, 4'h0, 0, 0, 0, F0); add(1, 4'h0, 0, 0, 1, F1); add(1, 4'h0, 0, 0, 2, 0);
      // ADD / SUB with a junk opcode during fetch
      add(1, 4'hF, 0, 0, 0, F0); add(1, 4'hF, 0, 0, 1, F1); add(1, 4'h2, 0, 0, 2, M_IO | M_MI);
      add(1, 4'h2, 1, 1, 3, M_RO | M_BI); add(1, 4'h2, 0, 0, 4, M_EO | M_AI | M_FI);
      add(1, 4'hF, 0, 0, 0, F0); add(1, 4'hF, 0, 0, 1, F1); add(1, 4'h3, 0, 0, 2, M_IO | M_MI);
      add(1, 4'h3, 0, 0, 3, M_RO | M_BI); add(1, 4'h3, 0, 0, 4, M_EO | M_AI | M_FI | M_SU);
      // LDA, STA, LDI, JMP, OUT
      add(1, 4'h1, 0, 0, 0, F0); add(1, 4'h1, 0, 0, 1, F1); add(1, 4'h1, 0, 0, 2, M_IO | M_MI);
      add(1, 4'h1, 0, 0, 3, M_RO | M_AI);
      add(1, 4'h4, 0, 0, 0, F0); add(1, 4'h4, 0, 0, 1, F1); add(1, 4'h4, 0, 0, 2, M_IO | M_MI);
      add(1, 4'h4, 0, 0, 3, M_AO | M_RI);
      add(1, 4'h5, 0, 0, 0, F0); add(1, 4'h5, 0, 0, 1, F1); add(1, 4'h5, 0, 0, 2, M_IO | M_AI);
      add(1, 4'h6, 0, 0, 0, F0); add(1, 4'h6, 0, 0, 1, F1); add(1, 4'h6, 0, 0, 2, M_IO | M_J);
      add(1, 4'hE, 0, 0, 0, F0); add(1, 4'hE, 0, 0, 1, F1); add(1, 4'hE, 0, 0, 2, M_AO | M_OI);
      // JC / JZ taken and not taken; the other flag is irrelevant
      add(1, 4'h7, 0, 0, 0, F0); add(1, 4'h7, 0, 0, 1, F1); add(1, 4'h7, 1, 0, 2, M_IO | M_J);
      add(1, 4'h7, 0, 0, 0, F0); add(1, 4'h7, 0, 0, 1, F1); add(1, 4'h7, 0, 1, 2, 0);
      add(1, 4'h8, 0, 0, 0, F0); add(1, 4'h8, 0, 0, 1, F1); add(1, 4'h8, 0, 1, 2, M_IO | M_J);
      add(1, 4'h8, 0, 0, 0, F0); add(1, 4'h8, 0, 0, 1, F1); add(1, 4'h8, 1, 0, 2, 0);
      // reset during T3 of LDA
      add(1, 4'h1, 0, 0, 0, F0); add(1, 4'h1, 0, 0, 1, F1); add(1, 4'h1, 0, 0, 2, M_IO | M_MI);
      add(0, 4'h1, 0, 0, 3, 0); add(1, 4'h1, 0, 0, 0, F0); add(1, 4'h1, 0, 0, 1, F1);
      add(1, 4'h1, 0, 0, 2, M_IO | M_MI); add(1, 4'h1, 0, 0, 3, M_RO | M_AI);
      // HLT entry
      add(1, 4'hF, 0, 0, 0, F0); add(1, 4'hF, 0, 0, 1, F1); add(1, 4'hF, 0, 0, 2, M_HLT);

      repeat (2) @(posedge clk);
      foreach (vecs[i]) begin
         drive(vecs[i].r, vecs[i].op, vecs[i].c, vecs[i].z);
         check($sformatf("vec%0d", i), vecs[i].st, vecs[i].ctl);
      end

      // halted: frozen regardless of inputs, only reset exits
      for (int k = 0; k < 20; k++) begin
         drive(1, 4'(k), k[0], k[1]);
         check($sformatf("halt%0d", k), 3'd2, M_HLT);
      end
      drive(0, 4'h0, 0, 0);
      check("halt_rst", 3'd2, 0);
      drive(1, 4'h0, 0, 0);
      check("halt_exit", 3'd0, F0);

      // sweep: bus exclusivity everywhere, undefined opcodes trace as NOP
      for (int op = 0; op < 16; op++) begin
         for (int f = 0; f < 4; f++) begin
            drive(0, 4'(op), f[0], f[1]);
            for (int k = 0; k < 6; k++) begin
               drive(1, 4'(op), f[0], f[1]);
               tests++;
               if ($countones(ctrl & BUS) > 1) begin
                  fails++;
                  $display("FAIL bus_excl op=%0d f=%0d k=%0d: drivers=%05h, required at most one", op, f, k, ctrl & BUS);
               end
               if (op >= 9 && op <= 13)
                  check($sformatf("undef op=%0d f=%0d k=%0d", op, f, k), 3'(k % 3),
                        (k % 3 == 0) ? F0 : (k % 3 == 1) ? F1 : 17'h0);
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
